prim_clock_mux_ctrl: RTL

PRIM_CLOCK_MUX_CTRL -- requirements
Module: prim_clock_mux_ctrl

---
 rtl/prim_clock_mux_ctrl_if.sv | 30 +++
 rtl/prim_clock_mux_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/prim_clock_mux_ctrl_if.sv
// rtl/prim_clock_mux_ctrl_if.sv - request/status bundle between a requester and the clock mux controller
interface prim_clock_mux_ctrl_if;
    logic req_i;
    logic req_sel_i;
    logic sel_o;
    logic clk_en_o;
    logic busy_o;
    logic ack_o;
    logic err_o;

    modport master (
        output req_i,
        output req_sel_i,
        input  sel_o,
        input  clk_en_o,
        input  busy_o,
        input  ack_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  req_sel_i,
        output sel_o,
        output clk_en_o,
        output busy_o,
        output ack_o,
        output err_o
    );
endinterface

// File: rtl/prim_clock_mux_ctrl.sv
// rtl/prim_clock_mux_ctrl.sv - glitch-free clock mux select sequencer (gate off, switch, gate on)
module prim_clock_mux_ctrl #(
    parameter int   SettleCycles = 4,
    parameter logic ResetSel     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    prim_clock_mux_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2
    } state_t;

    // Each gated phase lasts SettleCycles cycles: load N-1 and leave at zero.
    localparam logic [7:0] LP_RELOAD = 8'(SettleCycles - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_tgt;
    logic       r_sel;
    logic       r_clk_en;
    logic       r_busy;
    logic       r_ack;
    logic       r_err;

    // Sequencer: all outputs are flops so nothing on req_i reaches an output combinationally.
    // A dropped request arriving in the final SWITCH cycle gets no err_o, because ack_o
    // fires that same cycle and the two pulses must never coincide.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_tgt    <= ResetSel;
            r_sel    <= ResetSel;
            r_clk_en <= 1'b1;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_i) begin
                        if (bus.req_sel_i != r_sel) begin
                            r_state  <= GATE_OFF;
                            r_clk_en <= 1'b0;
                            r_busy   <= 1'b1;
                            r_cnt    <= LP_RELOAD;
                            r_tgt    <= bus.req_sel_i;
                        end else begin
                            r_ack <= 1'b1;
                        end
                    end
                end
                GATE_OFF: begin
                    r_err <= bus.req_i;
                    if (r_cnt == 8'd0) begin
                        r_state <= SWITCH;
                        r_sel   <= r_tgt;
                        r_cnt   <= LP_RELOAD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                SWITCH: begin
                    if (r_cnt == 8'd0) begin
                        r_state  <= IDLE;
                        r_clk_en <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ack    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        r_err <= bus.req_i;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_clk_en <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel_o    = r_sel;
    assign bus.clk_en_o = r_clk_en;
    assign bus.busy_o   = r_busy;
    assign bus.ack_o    = r_ack;
    assign bus.err_o    = r_err;

endmodule
